// File: rtl/hex2ascii_pkg.sv
// rtl/hex2ascii_pkg.sv - shared FSM states, ASCII constants and nibble conversion for hex2ascii_stream
`timescale 1ns/1ps
package hex2ascii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PFX0,
    ST_PFX1,
    ST_DIGIT,
    ST_TERM
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Digits map from '0'; letters map from 'A' or 'a' minus ten.
  function automatic logic [7:0] nib2char(input logic [3:0] nibble, input logic lower);
    logic [7:0] w_n;
    w_n = {4'h0, nibble};
    if (nibble < 4'd10) return ASCII_0 + w_n;
    return (lower ? 8'h61 : 8'h41) + (w_n - 8'd10);
  endfunction

endpackage

// File: rtl/hex2ascii_stream.sv
// rtl/hex2ascii_stream.sv - streams a captured word as ASCII hex, optional "0x" prefix and LF terminator
`timescale 1ns/1ps
module hex2ascii_stream
  import hex2ascii_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PREFIX_EN = 1,
  parameter int TERM_EN   = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lower,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NIB - 1);
  localparam bit DIGIT_LAST = (TERM_EN == 0);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("hex2ascii_stream: illegal WIDTH %0d", WIDTH);
  end

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic             r_lower, w_lower_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [7:0]       r_char, w_char_nxt;
  logic             r_last, w_last_nxt;
  logic             w_xfer;

  function automatic logic [3:0] nib_at(input logic [WIDTH-1:0] d, input logic [IW-1:0] i);
    logic [WIDTH-1:0] w_s;
    w_s = d >> {i, 2'b00};
    return w_s[3:0];
  endfunction

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state != ST_IDLE);
  assign out_char  = r_char;
  assign out_last  = r_last;
  assign w_xfer    = out_valid && out_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_lower <= 1'b0;
      r_idx   <= '0;
      r_char  <= 8'h00;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_lower <= w_lower_nxt;
      r_idx   <= w_idx_nxt;
      r_char  <= w_char_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // The character register is loaded with the next character on the edge that
  // enters a state, so out_char is already valid when the state shows it.
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_lower_nxt = r_lower;
    w_idx_nxt   = r_idx;
    w_char_nxt  = r_char;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_data_nxt  = in_data;
          w_lower_nxt = in_lower;
          w_idx_nxt   = IDX_TOP;
          if (PREFIX_EN != 0) begin
            w_state_nxt = ST_PFX0;
            w_char_nxt  = ASCII_0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_DIGIT;
            w_char_nxt  = nib2char(nib_at(in_data, IDX_TOP), in_lower);
            w_last_nxt  = DIGIT_LAST && (NIB == 1);
          end
        end
      end
      ST_PFX0: begin
        if (w_xfer) begin
          w_state_nxt = ST_PFX1;
          w_char_nxt  = ASCII_X;
        end
      end
      ST_PFX1: begin
        if (w_xfer) begin
          w_state_nxt = ST_DIGIT;
          w_char_nxt  = nib2char(nib_at(r_data, IDX_TOP), r_lower);
          w_last_nxt  = DIGIT_LAST && (NIB == 1);
        end
      end
      ST_DIGIT: begin
        if (w_xfer) begin
          if (r_idx == '0) begin
            if (TERM_EN != 0) begin
              w_state_nxt = ST_TERM;
              w_char_nxt  = ASCII_LF;
              w_last_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_char_nxt  = 8'h00;
              w_last_nxt  = 1'b0;
            end
          end else begin
            w_idx_nxt  = r_idx - 1'b1;
            w_char_nxt = nib2char(nib_at(r_data, r_idx - 1'b1), r_lower);
            w_last_nxt = DIGIT_LAST && (r_idx == IW'(1));
          end
        end
      end
      ST_TERM: begin
        if (w_xfer) begin
          w_state_nxt = ST_IDLE;
          w_char_nxt  = 8'h00;
          w_last_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hex2ascii_stream.sv
// tb/tb_hex2ascii_stream.sv - scoreboard bench for hex2ascii_stream, default and 8-bit bare configurations
`timescale 1ns/1ps
module tb_hex2ascii_stream;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;

  logic        in_valid0 = 1'b0, in_lower0 = 1'b0, out_ready0 = 1'b1;
  logic [31:0] in_data0 = '0;
  logic        in_ready0, out_valid0, out_last0;
  logic [7:0]  out_char0;

  logic        in_valid1 = 1'b0, in_lower1 = 1'b0, out_ready1 = 1'b1;
  logic [7:0]  in_data1 = '0;
  logic        in_ready1, out_valid1, out_last1;
  logic [7:0]  out_char1;

  int errors = 0;
  int checks = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic       hold0 = 1'b0;
  logic [8:0] held0 = '0;

  always #5 clk = ~clk;

  hex2ascii_stream dut0 (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_lower(in_lower0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_char(out_char0), .out_last(out_last0)
  );

  hex2ascii_stream #(.WIDTH(8), .PREFIX_EN(0), .TERM_EN(0)) dut1 (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_lower(in_lower1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_char(out_char1), .out_last(out_last1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [63:0] d, input logic lo,
                      input int w, input int pfx, input int term);
    string hx;
    logic [8:0] item;
    logic [63:0] sh;
    hx = lo ? "0123456789abcdef" : "0123456789ABCDEF";
    if (pfx != 0) begin
      item = {1'b0, 8'h30}; if (sel == 0) q0.push_back(item); else q1.push_back(item);
      item = {1'b0, 8'h78}; if (sel == 0) q0.push_back(item); else q1.push_back(item);
    end
    for (int k = w / 4 - 1; k >= 0; k--) begin
      sh = d >> (4 * k);
      item = {(term == 0 && k == 0), hx[int'(sh[3:0])]};
      if (sel == 0) q0.push_back(item); else q1.push_back(item);
    end
    if (term != 0) begin
      item = {1'b1, 8'h0A}; if (sel == 0) q0.push_back(item); else q1.push_back(item);
    end
  endtask

  // Scoreboard and hold-stability monitors, sampled on the falling edge.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!nrst) begin
      hold0 = 1'b0;
    end else begin
      if (hold0 && out_valid0) chk("hold_stable0", {23'd0, out_last0, out_char0}, {23'd0, held0});
      if (out_valid0 && out_ready0) begin
        checks++;
        assert (q0.size() != 0) else begin
          errors++;
          $error("FAIL spurious_char0 observed=%h expected=none", out_char0);
        end
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("char0", {23'd0, out_last0, out_char0}, {23'd0, e});
        end
      end
      hold0 = out_valid0 && !out_ready0;
      held0 = {out_last0, out_char0};
      if (out_valid1 && out_ready1) begin
        checks++;
        assert (q1.size() != 0) else begin
          errors++;
          $error("FAIL spurious_char1 observed=%h expected=none", out_char1);
        end
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("char1", {23'd0, out_last1, out_char1}, {23'd0, e});
        end
      end
    end
  end

  task automatic send0(input logic [31:0] d, input logic lo);
    int n = 0;
    while (!in_ready0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("accept_ready0", {31'd0, in_ready0}, 32'd1);
    push(0, {32'd0, d}, lo, 32, 1, 1);
    in_valid0 = 1'b1; in_data0 = d; in_lower0 = lo;
    @(posedge clk); #1;
    in_valid0 = 1'b0; in_data0 = $urandom; in_lower0 = ~lo;
  endtask

  task automatic drain0(input string tag);
    int n = 0;
    while ((q0.size() != 0 || !in_ready0) && n < 300) begin @(posedge clk); #1; n++; end
    chk(tag, {31'd0, (n >= 300)}, 32'd0);
  endtask

  initial begin
    int p;
    #12;
    chk("rst_in_ready0", {31'd0, in_ready0}, 32'd1);
    chk("rst_out_valid0", {31'd0, out_valid0}, 32'd0);
    chk("rst_out_char0", {24'd0, out_char0}, 32'h00);
    chk("rst_out_last0", {31'd0, out_last0}, 32'd0);
    chk("rst_out_valid1", {31'd0, out_valid1}, 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;

    // "0xDEADBEEF\n", one character per cycle, then IDLE
    send0(32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 11; i++) begin
      chk("stream_valid0", {31'd0, out_valid0}, 32'd1);
      @(posedge clk); #1;
    end
    chk("idle_after_word0", {31'd0, in_ready0}, 32'd1);
    drain0("drain_deadbeef");

    send0(32'hABCDEF09, 1'b1);
    drain0("drain_lower");

    // 8-bit bare configuration
    push(1, 64'h3C, 1'b1, 8, 0, 0);
    in_valid1 = 1'b1; in_data1 = 8'h3C; in_lower1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_data1 = 8'h55; in_lower1 = 1'b0;
    chk("w8_first_char", {24'd0, out_char1}, 32'h33);
    @(posedge clk); #1;
    chk("w8_last_char", {23'd0, out_last1, out_char1}, {23'd0, 1'b1, 8'h63});
    @(posedge clk); #1;
    chk("w8_ready_back", {31'd0, in_ready1}, 32'd1);
    chk("w8_queue_empty", q1.size(), 32'd0);

    // Stalled sink: 1,0,0 repeating
    send0(32'h0000000A, 1'b0);
    p = 0;
    while ((q0.size() != 0 || !in_ready0) && p < 300) begin
      out_ready0 = (p % 3 == 0);
      p++;
      @(posedge clk); #1;
    end
    chk("stall_timeout", {31'd0, (p >= 300)}, 32'd0);
    out_ready0 = 1'b1;

    // Back-to-back with in_valid held high
    push(0, 64'h12345678, 1'b0, 32, 1, 1);
    in_valid0 = 1'b1; in_data0 = 32'h12345678; in_lower0 = 1'b0;
    @(posedge clk); #1;
    in_data0 = 32'hFFFFFFFF; in_lower0 = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    in_data0 = 32'h9ABCDEF0; in_lower0 = 1'b0;
    push(0, 64'h9ABCDEF0, 1'b0, 32, 1, 1);
    repeat (6) begin @(posedge clk); #1; end
    chk("b2b_idle_gap", {31'd0, in_ready0}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_second_accept", {31'd0, out_valid0}, 32'd1);
    in_valid0 = 1'b0; in_data0 = $urandom;
    drain0("drain_b2b");

    // Reset during the 4th digit
    send0(32'hFFFFFFFF, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    chk("mid_word_pending", q0.size(), 32'd6);
    nrst = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("rst_mid_out_char", {24'd0, out_char0}, 32'h00);
    chk("rst_mid_out_last", {31'd0, out_last0}, 32'd0);
    q0.delete();
    @(posedge clk); #1;
    chk("rst_hold_out_valid", {31'd0, out_valid0}, 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;
    send0(32'h00000001, 1'b0);
    drain0("drain_after_reset");

    chk("final_q0_empty", q0.size(), 32'd0);
    chk("final_q1_empty", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
